// File: rtl/seven_seg_pkg.sv
// Shared seven-segment glyph table (bit0=a .. bit6=g, active-high), used by
// both the hex-to-segment encoder and the capture-side decoder.
package seven_seg_pkg;

  localparam int unsigned SEG_W    = 7;
  localparam int unsigned NIBBLE_W = 4;

  localparam logic [SEG_W-1:0] GLYPH_0     = 7'h3F;
  localparam logic [SEG_W-1:0] GLYPH_1     = 7'h06;
  localparam logic [SEG_W-1:0] GLYPH_2     = 7'h5B;
  localparam logic [SEG_W-1:0] GLYPH_3     = 7'h4F;
  localparam logic [SEG_W-1:0] GLYPH_4     = 7'h66;
  localparam logic [SEG_W-1:0] GLYPH_5     = 7'h6D;
  localparam logic [SEG_W-1:0] GLYPH_6     = 7'h7D;
  localparam logic [SEG_W-1:0] GLYPH_7     = 7'h07;
  localparam logic [SEG_W-1:0] GLYPH_8     = 7'h7F;
  localparam logic [SEG_W-1:0] GLYPH_9     = 7'h67;
  localparam logic [SEG_W-1:0] GLYPH_A     = 7'h77;
  localparam logic [SEG_W-1:0] GLYPH_B     = 7'h7C;
  localparam logic [SEG_W-1:0] GLYPH_C     = 7'h39;
  localparam logic [SEG_W-1:0] GLYPH_D     = 7'h5E;
  localparam logic [SEG_W-1:0] GLYPH_E     = 7'h79;
  localparam logic [SEG_W-1:0] GLYPH_F     = 7'h71;
  localparam logic [SEG_W-1:0] GLYPH_BLANK = 7'h00;

endpackage

// File: rtl/seven_seg_to_hex.sv
// Combinational inverse of the hex-to-segment encoder: segment pattern back
// to nibble, with flags for a recognised glyph and for a blank digit.
module seven_seg_to_hex
  import seven_seg_pkg::*;
(
  input  logic [SEG_W-1:0]    i_seg,
  output logic [NIBBLE_W-1:0] o_nibble_c,
  output logic                o_is_glyph_c,
  output logic                o_is_blank_c
);

  always_comb begin
    o_nibble_c   = '0;
    o_is_glyph_c = 1'b1;
    o_is_blank_c = (i_seg == GLYPH_BLANK);
    case (i_seg)
      GLYPH_0: o_nibble_c = 4'h0;
      GLYPH_1: o_nibble_c = 4'h1;
      GLYPH_2: o_nibble_c = 4'h2;
      GLYPH_3: o_nibble_c = 4'h3;
      GLYPH_4: o_nibble_c = 4'h4;
      GLYPH_5: o_nibble_c = 4'h5;
      GLYPH_6: o_nibble_c = 4'h6;
      GLYPH_7: o_nibble_c = 4'h7;
      GLYPH_8: o_nibble_c = 4'h8;
      GLYPH_9: o_nibble_c = 4'h9;
      GLYPH_A: o_nibble_c = 4'hA;
      GLYPH_B: o_nibble_c = 4'hB;
      GLYPH_C: o_nibble_c = 4'hC;
      GLYPH_D: o_nibble_c = 4'hD;
      GLYPH_E: o_nibble_c = 4'hE;
      GLYPH_F: o_nibble_c = 4'hF;
      default: o_is_glyph_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_seg_capture.sv
// Receive side of the multiplexed seven-segment bus: synchronise, wait for a
// stable single-digit pattern, decode it and assemble the hex word.
module seven_seg_capture
  import seven_seg_pkg::*;
#(
  parameter int unsigned N_DIGITS      = 4,
  parameter int unsigned STABLE_CYCLES = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [SEG_W-1:0]        i_seg,
  input  logic [N_DIGITS-1:0]     i_an,
  output logic [4*N_DIGITS-1:0]   o_data,
  output logic [N_DIGITS-1:0]     o_digit_valid,
  output logic [N_DIGITS-1:0]     o_err,
  output logic                    o_frame_valid
);

  localparam int unsigned SW = SEG_W + N_DIGITS;
  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);

  logic [SW-1:0]         r_sync1, r_sync2, r_prev;
  logic [CW-1:0]         r_cnt;
  logic [N_DIGITS-1:0]   r_seen;
  logic [4*N_DIGITS-1:0] r_data;
  logic [N_DIGITS-1:0]   r_digit_valid, r_err;
  logic                  r_frame_valid;

  logic [SEG_W-1:0]      w_seg;
  logic [N_DIGITS-1:0]   w_an_act, w_sel, w_seen_next;
  logic                  w_same, w_accept;
  logic [NIBBLE_W-1:0]   w_nibble;
  logic                  w_is_glyph, w_is_blank;

  assign w_seg       = r_sync2[SEG_W-1:0];
  assign w_an_act    = ~r_sync2[SW-1:SEG_W];
  assign w_same      = (r_sync2 == r_prev);
  // Fires only on the 7->8 style transition of the counter, so once per stable period
  assign w_accept    = w_same && (r_cnt == CW'(STABLE_CYCLES - 1)) && $onehot(w_an_act);
  assign w_sel       = w_accept ? w_an_act : '0;
  assign w_seen_next = r_seen | w_sel;

  seven_seg_to_hex u_dec (
    .i_seg        (w_seg),
    .o_nibble_c   (w_nibble),
    .o_is_glyph_c (w_is_glyph),
    .o_is_blank_c (w_is_blank)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1       <= '0;
      r_sync2       <= '0;
      r_prev        <= '0;
      r_cnt         <= '0;
      r_seen        <= '0;
      r_data        <= '0;
      r_digit_valid <= '0;
      r_err         <= '0;
      r_frame_valid <= 1'b0;
    end else begin
      r_sync1 <= {i_an, i_seg};
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;

      if (!w_same)
        r_cnt <= '0;
      else if (r_cnt != CW'(STABLE_CYCLES))
        r_cnt <= r_cnt + 1'b1;

      // Mask full after the completing accept: pulse and start a fresh frame
      if (&r_seen) begin
        r_frame_valid <= 1'b1;
        r_seen        <= '0;
      end else begin
        r_frame_valid <= 1'b0;
        r_seen        <= w_seen_next;
      end

      for (int k = 0; k < int'(N_DIGITS); k++) begin
        if (w_sel[k]) begin
          if (w_is_glyph) begin
            r_data[4*k +: 4] <= w_nibble;
            r_digit_valid[k] <= 1'b1;
            r_err[k]         <= 1'b0;
          end else begin
            r_digit_valid[k] <= 1'b0;
            r_err[k]         <= !w_is_blank;
          end
        end
      end
    end
  end

  assign o_data        = r_data;
  assign o_digit_valid = r_digit_valid;
  assign o_err         = r_err;
  assign o_frame_valid = r_frame_valid;

endmodule
